// File: rtl/rr_quota_arbiter.sv
// Round-robin arbiter with a per-grant hold quota: one registered, one-hot grant at a time.
// An owner is forced off after MAX_HOLD cycles only when another requester is waiting.
module rr_quota_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic [NREQ-1:0]                     req_i,
    output logic [NREQ-1:0]                     grant_o,
    output logic                                grant_valid_o,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id_o,
    output logic                                expired_o
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  owner_q;
    logic [IDW-1:0]  ptr_q;
    logic [7:0]      cnt_q;
    logic [NREQ-1:0] grant_q;
    logic            grant_valid_q;
    logic [IDW-1:0]  grant_id_q;
    logic            expired_q;

    logic            pick_found_d;
    logic [IDW-1:0]  pick_id_d;
    logic [IDW-1:0]  ptr_d;
    logic            others_d;

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
        logic [NREQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Rotated priority search starting at ptr_q; first hit wins.
    always_comb begin
        logic [IDW-1:0] idx;
        pick_found_d = 1'b0;
        pick_id_d    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NREQ);
            if (!pick_found_d && req_i[idx]) begin
                pick_found_d = 1'b1;
                pick_id_d    = idx;
            end else begin
                pick_found_d = pick_found_d;
            end
        end
    end

    // Pointer after a release, and whether anyone besides the owner is waiting.
    always_comb begin
        others_d = |(req_i & ~onehot(owner_q));
        if (owner_q == IDW'(NREQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = owner_q + IDW'(1);
        end
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            ptr_q         <= '0;
            cnt_q         <= 8'd0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            expired_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    expired_q <= 1'b0;
                    if (pick_found_d) begin
                        state_q       <= ST_GRANT;
                        owner_q       <= pick_id_d;
                        cnt_q         <= 8'd1;
                        grant_q       <= onehot(pick_id_d);
                        grant_valid_q <= 1'b1;
                        grant_id_q    <= pick_id_d;
                    end else begin
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        grant_id_q    <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!req_i[owner_q]) begin
                        state_q       <= ST_IDLE;
                        ptr_q         <= ptr_d;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        grant_id_q    <= '0;
                        expired_q     <= 1'b0;
                    end else if (cnt_q < 8'(MAX_HOLD)) begin
                        cnt_q     <= cnt_q + 8'd1;
                        expired_q <= 1'b0;
                    end else if (others_d) begin
                        // Quota reached under contention: yield with an expiry pulse.
                        state_q       <= ST_IDLE;
                        ptr_q         <= ptr_d;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        grant_id_q    <= '0;
                        expired_q     <= 1'b1;
                    end else begin
                        expired_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    grant_q       <= '0;
                    grant_valid_q <= 1'b0;
                    grant_id_q    <= '0;
                    expired_q     <= 1'b0;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = grant_valid_q;
    assign grant_id_o    = grant_id_q;
    assign expired_o     = expired_q;

endmodule

// File: tb/tb_rr_quota_arbiter.sv
// Scoreboard bench for rr_quota_arbiter: a cycle-level reference model pushes expected
// outputs each edge, and a monitor pops and compares them half a cycle later.
module tb_rr_quota_arbiter;
    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         expired;

    typedef struct packed {
        logic [N-1:0] g;
        logic         v;
        logic [1:0]   id;
        logic         ex;
    } exp_t;

    exp_t exp_q[$];
    bit   armed = 1'b0;
    int   total = 0;
    int   bad   = 0;

    rr_quota_arbiter #(.NREQ(N), .MAX_HOLD(MH)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .req_i        (req),
        .grant_o      (grant),
        .grant_valid_o(grant_valid),
        .grant_id_o   (grant_id),
        .expired_o    (expired)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the resource, how long, and where the rotation starts.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_held  = 0;

    always @(posedge clk) begin
        exp_t e;
        int best, bestd, d;
        e = '0;
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_held = 0;
        end else if (!m_busy) begin
            best  = -1;
            bestd = N;
            for (int i = 0; i < N; i++) begin
                d = (i - m_ptr + N) % N;
                if (req[i] && d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
            if (best >= 0) begin
                m_busy  = 1'b1;
                m_owner = best;
                m_held  = 1;
                e.g     = N'(1) << best;
                e.v     = 1'b1;
                e.id    = 2'(best);
            end
        end else if (!req[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
        end else if (m_held >= MH && (req & ~(N'(1) << m_owner)) != '0) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
            e.ex   = 1'b1;
        end else begin
            m_held = m_held + 1;
            e.g    = N'(1) << m_owner;
            e.v    = 1'b1;
            e.id   = 2'(m_owner);
        end
        exp_q.push_back(e);
        armed = 1'b1;
    end

    // Monitor: compare DUT outputs against the oldest expectation, plus structural checks.
    logic [N-1:0] prev_grant = '0;
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty: no expectation for grant=%b", grant);
            end else begin
                e = exp_q.pop_front();
                if (grant !== e.g || grant_valid !== e.v || grant_id !== e.id || expired !== e.ex) begin
                    bad++;
                    $display("FAIL outputs @%0t: got g=%b v=%b id=%0d ex=%b, want g=%b v=%b id=%0d ex=%b",
                             $time, grant, grant_valid, grant_id, expired, e.g, e.v, e.id, e.ex);
                end
            end
            total++;
            if (!$onehot0(grant) || (prev_grant != '0 && grant != '0 && grant != prev_grant)) begin
                bad++;
                $display("FAIL grant_shape @%0t: got prev=%b cur=%b, want one-hot with gap", $time, prev_grant, grant);
            end
            prev_grant = grant;
        end
    end

    task automatic apply(input logic [N-1:0] r, input logic rs, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            req = r;
            rst = rs;
        end
    endtask

    initial begin
        logic [N-1:0] r;
        // Directed scenarios
        apply(4'b1111, 1'b1, 3);
        apply(4'b1111, 1'b0, 2);
        apply(4'b0000, 1'b0, 2);
        apply(4'b0100, 1'b0, 20);
        apply(4'b0000, 1'b0, 2);
        apply(4'b0011, 1'b0, 40);
        apply(4'b0000, 1'b0, 2);
        apply(4'b1111, 1'b1, 1);
        apply(4'b1111, 1'b0, 11);
        apply(4'b1011, 1'b0, 1);
        apply(4'b1111, 1'b0, 22);
        apply(4'b0000, 1'b0, 2);
        apply(4'b0011, 1'b1, 1);
        apply(4'b0011, 1'b0, 8);
        apply(4'b0010, 1'b0, 3);
        apply(4'b0000, 1'b0, 2);
        apply(4'b0010, 1'b0, 4);
        apply(4'b1111, 1'b0, 4);
        apply(4'b1111, 1'b1, 1);
        apply(4'b1111, 1'b0, 3);
        // Randomized phase: sticky request bits with occasional toggles and resets
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            end
            apply(r, ($urandom_range(0, 299) == 0), 1);
        end
        apply(4'b0000, 1'b0, 3);
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
